wallace_mult_pipe: RTL
======================

WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter PW, default 2*WIDTH, product width; not overridable.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port a  input  WIDTH  multiplicand.
REQ-006 SHALL have port b  input  WIDTH  multiplier.
REQ-007 SHALL have port tc  input  1  two's-complement operand mode, sampled with a/b.
REQ-008 SHALL have port in_valid  input  1  a/b/tc valid.
REQ-009 SHALL have port in_ready  output  1  stage 1 can accept.
REQ-010 SHALL have port p  output  PW  product.
REQ-011 SHALL have port p_tc  output  1  tc of the transaction on p.
REQ-012 SHALL have port out_valid  output  1  p valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts p.

Function
REQ-014 SHALL generate WIDTH*WIDTH partial products and reduce them with a generate-built Wallace tree (FA 3:2, HA 2:2 per column) to two PW-bit rows, sum and carry.
REQ-015 SHALL register the two rows plus tc in stage 1 (s1_valid) and the final carry-propagate sum in stage 2 (s2_valid drives out_valid).
REQ-016 SHALL have latency 2 cycles from input handshake (in_valid && in_ready) to out_valid, with no stall.
REQ-017 SHALL sustain one transaction per cycle while out_ready is held high.
REQ-018 SHALL advance stage 2 when !s2_valid || out_ready; advance stage 1 when !s1_valid || stage 2 advances; in_ready = stage 1 advance condition (combinational, no dependence on in_valid).
REQ-019 SHALL hold p, p_tc and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL never drop, duplicate or reorder transactions under any in_valid/out_ready pattern.
REQ-021 SHALL take p as the sum of the two rows modulo 2^PW; carry out of bit PW-1 is discarded.
REQ-022 SHALL, when tc=0, produce p = unsigned a * unsigned b.
REQ-023 SHALL, when tc=1 (subject to REQ-030), produce p = signed a * signed b, using Baugh-Wooley inversion of MSB-row/column partial products plus constant 1s at bits WIDTH and PW-1.
REQ-024 SHALL, on simultaneous input and output handshakes, move every stage in the same cycle.
REQ-025 SHALL leave stage registers unchanged when a stage does not advance; bubbles (valid=0) may carry don't-care data, but p SHALL read 0 when out_valid=0.

Reset
REQ-026 SHALL, when rst is asserted, immediately clear s1_valid, s2_valid and out_valid, force p=0 and p_tc=0, and clear stage 1 rows.
REQ-027 SHALL discard in-flight transactions on reset mid-operation; no output for them appears after reset.
REQ-028 SHALL assert in_ready in the first cycle after rst deasserts.
REQ-029 SHALL keep in_ready low while rst is high.

Configuration
REQ-030 SHALL honour tc only with macro WALLACE_SIGNED_EN defined; without it, tc is ignored, treated as 0 internally, and Baugh-Wooley logic is not built.
REQ-031 SHALL, without WALLACE_SIGNED_EN, still drive p_tc with the sampled tc pin value.
REQ-032 SHALL have identical latency, handshake and reset behaviour with or without WALLACE_SIGNED_EN.

Verification (WIDTH=8 unless noted)
REQ-033 SHALL cover unsigned max: a=0xFF, b=0xFF, tc=0, out_ready=1 -> p=0xFE01, two cycles after the handshake.
REQ-034 SHALL cover signed products, with WALLACE_SIGNED_EN: a=0x80, b=0x80, tc=1 -> p=0x4000; a=0xFF, b=0x01, tc=1 -> p=0xFFFF. Without the macro, the same inputs -> p=0x4000 and p=0x00FF.
REQ-035 SHALL cover back-pressure: back-to-back inputs 3x5, 7x9, 11x13, 2x2 with out_ready low for 3 cycles from the first out_valid -> in_ready falls after 2 inputs held, p holds 0x000F stably, then outputs 0x000F, 0x003F, 0x008F, 0x0004 in order with none lost.
REQ-036 SHALL cover reset mid-flight: 2 transactions accepted, rst pulsed before either is output -> out_valid=0, p=0 during reset, no stale output afterwards, in_ready=1 in the first post-reset cycle.
REQ-037 SHALL cover a random sweep: WIDTH=3, 6, 16, 10k random operands, random in_valid/out_ready, both tc values -> every p matches the reference model in order.

Source files
------------

// File: rtl/wallace_mult_pipe.sv
// Two-stage pipelined WIDTH x WIDTH multiplier: Wallace carry-save tree, then registered carry-propagate add.
// Define WALLACE_SIGNED_EN to build the Baugh-Wooley signed mode selected by tc; otherwise tc only rides along to p_tc.
module wallace_mult_pipe #(
  parameter  int WIDTH = 8,
  localparam int PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             tc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PW-1:0]    p,
  output logic             p_tc,
  output logic             out_valid,
  input  logic             out_ready
);

`ifdef WALLACE_SIGNED_EN
  localparam int NPP = WIDTH + 1;
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
`else
  localparam int NPP = WIDTH;
`endif

  function automatic int rows_after(input int lvl);
    int n;
    n = NPP;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = NPP;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  localparam int NLEV = num_levels();

  // tree[l][r] is row r after l reduction levels; rows past the live count are tied to zero.
  logic [PW-1:0] tree [0:NLEV][0:NPP-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
    logic [WIDTH-1:0] pp;
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_bit
`ifdef WALLACE_SIGNED_EN
      if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin : g_bw
        assign pp[j] = (a[j] & b[i]) ^ tc;
      end else begin : g_plain
        assign pp[j] = a[j] & b[i];
      end
`else
      assign pp[j] = a[j] & b[i];
`endif
    end
    assign tree[0][i] = {{WIDTH{1'b0}}, pp} << i;
  end

`ifdef WALLACE_SIGNED_EN
  assign tree[0][WIDTH] = tc ? BW_CONST : '0;
`endif

  // Each level: FA per column on every full group of three rows, HA on a leftover pair, pass a single leftover.
  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int N    = rows_after(l);
    localparam int NG   = N / 3;
    localparam int NOUT = rows_after(l + 1);
    for (genvar g = 0; g < NG; g++) begin : g_fa
      assign tree[l+1][2*g]   = tree[l][3*g] ^ tree[l][3*g+1] ^ tree[l][3*g+2];
      assign tree[l+1][2*g+1] = ((tree[l][3*g] & tree[l][3*g+1]) |
                                 (tree[l][3*g] & tree[l][3*g+2]) |
                                 (tree[l][3*g+1] & tree[l][3*g+2])) << 1;
    end
    if (N % 3 == 2) begin : g_ha
      assign tree[l+1][2*NG]   = tree[l][3*NG] ^ tree[l][3*NG+1];
      assign tree[l+1][2*NG+1] = (tree[l][3*NG] & tree[l][3*NG+1]) << 1;
    end else if (N % 3 == 1) begin : g_pass
      assign tree[l+1][2*NG] = tree[l][3*NG];
    end
    for (genvar r = NOUT; r < NPP; r++) begin : g_zero
      assign tree[l+1][r] = '0;
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready; ready never looks at valid,
  // and a stage only advances when its downstream stage is empty or advancing in the same cycle.
  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] sum_q, sum_d, carry_q, carry_d;
  logic          tc1_q, tc1_d;
  logic          s2_valid_q, s2_valid_d;
  logic [PW-1:0] p_q, p_d;
  logic          p_tc_q, p_tc_d;
  logic          s1_adv, s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    tc1_d      = tc1_q;
    s2_valid_d = s2_valid_q;
    p_d        = p_q;
    p_tc_d     = p_tc_q;
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        p_d    = sum_q + carry_q;
        p_tc_d = tc1_q;
      end
    end
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        sum_d   = tree[NLEV][0];
        carry_d = tree[NLEV][1];
        tc1_d   = tc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      carry_q    <= '0;
      tc1_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      p_q        <= '0;
      p_tc_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      tc1_q      <= tc1_d;
      s2_valid_q <= s2_valid_d;
      p_q        <= p_d;
      p_tc_q     <= p_tc_d;
    end
  end

  assign in_ready  = !rst && s1_adv;
  assign out_valid = s2_valid_q;
  assign p         = s2_valid_q ? p_q : '0;
  assign p_tc      = p_tc_q;

endmodule
